// File: rtl/uart_tx_feeder_pkg.sv
// Shared types and default sizes for the UART TX feeder and the UART TX top.
package uart_tx_feeder_pkg;

  localparam int DEFAULT_DATA_WIDTH   = 8;
  localparam int DEFAULT_DEPTH        = 8;
  localparam int DEFAULT_BUSY_TIMEOUT = 4;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_START = 2'd1,
    WAIT_DONE  = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO with a separate occupancy counter and a sticky overflow flag.
module uart_sync_fifo
  import uart_tx_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         wr_en,
  input  logic                         rd_en,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  wr_accept;
  logic                  pop;

  // Flags come from the registered count, so a pop cannot make room for a same-cycle write.
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign wr_accept = wr_en && !full;
  assign pop       = rd_en && !empty;
  assign rd_data   = mem[rd_ptr];

  // NOTE: storage has no reset; pointers and count define validity, so stale contents are never read.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({wr_accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Feeds buffered bytes to the UART transmitter one frame at a time, paced by its busy output.
module uart_tx_feeder
  import uart_tx_feeder_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int DEPTH        = DEFAULT_DEPTH,
  parameter int BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         wr_en,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         launch_err,
  input  logic                         tx_busy,
  output logic [DATA_WIDTH-1:0]        tx_p_data,
  output logic                         tx_data_valid
);

  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  feeder_state_t         state;
  feeder_state_t         next_state;
  logic [TW-1:0]         timer;
  logic [DATA_WIDTH-1:0] head;
  logic                  launch;
  logic                  timeout_hit;

  uart_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .rd_en    (launch),
    .rd_data  (head),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:       if (launch)        next_state = WAIT_START;
      WAIT_START: if (tx_busy)       next_state = WAIT_DONE;
                  else if (timeout_hit) next_state = IDLE;
      WAIT_DONE:  if (!tx_busy)      next_state = IDLE;
      default:                       next_state = IDLE;
    endcase
  end

  always_comb begin
    launch      = 1'b0;
    timeout_hit = 1'b0;
    unique case (state)
      IDLE:       launch      = !empty && !tx_busy;
      WAIT_START: timeout_hit = !tx_busy && (timer == TW'(BUSY_TIMEOUT - 1));
      default: ;
    endcase
  end

  // A launch that times out is treated as consumed; the byte is not retried.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer         <= '0;
      tx_p_data     <= '0;
      tx_data_valid <= 1'b0;
      launch_err    <= 1'b0;
    end else begin
      tx_data_valid <= launch;
      if (launch) begin
        tx_p_data <= head;
        timer     <= '0;
      end else if (state == WAIT_START && !tx_busy) begin
        timer <= timer + TW'(1);
      end
      if (timeout_hit) begin
        launch_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: a vector table plus hand-written multi-cycle sequences.
module tb_uart_tx_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic       overflow;
  logic       launch_err;
  logic       tx_busy;
  logic [7:0] tx_p_data;
  logic       tx_data_valid;

  int errors = 0;
  int checks = 0;

  logic [7:0] wr_q  [$];
  logic [7:0] exp_q [$];

  typedef struct {
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       busy;
    logic       valid;
    logic [7:0] p_data;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       lerr;
  } vec_t;

  vec_t vecs [17];

  always #5 clk = ~clk;

  uart_tx_feeder dut (
    .clk           (clk),
    .rst           (rst),
    .wr_data       (wr_data),
    .wr_en         (wr_en),
    .full          (full),
    .empty         (empty),
    .count         (count),
    .overflow      (overflow),
    .launch_err    (launch_err),
    .tx_busy       (tx_busy),
    .tx_p_data     (tx_p_data),
    .tx_data_valid (tx_data_valid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_quiet(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check("no_extra_pulse", 32'(tx_data_valid), 32'd0);
    end
  endtask

  // Drives queued writes one per cycle and models a transmitter busy for frame_len cycles per launch.
  task automatic run_model(input int frame_len, input int budget);
    int         busy_left;
    int         launches;
    int         target;
    logic [7:0] want;
    busy_left = 0;
    launches  = 0;
    want      = '0;
    target    = exp_q.size();
    tx_busy   = 1'b0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (wr_q.size() > 0) begin
        wr_en   = 1'b1;
        wr_data = wr_q.pop_front();
      end else begin
        wr_en = 1'b0;
      end
      step();
      if (tx_data_valid) begin
        check("launch_during_frame", 32'(busy_left), 32'd0);
        launches++;
        if (exp_q.size() > 0) begin
          want = exp_q.pop_front();
          check("launch_data", 32'(tx_p_data), 32'(want));
        end
        busy_left = frame_len;
        tx_busy   = 1'b1;
      end else if (busy_left > 0) begin
        check("p_data_stable", 32'(tx_p_data), 32'(want));
        busy_left--;
        if (busy_left == 0) tx_busy = 1'b0;
      end
      if (launches >= target && busy_left == 0 && wr_q.size() == 0) break;
    end
    wr_en = 1'b0;
    check("launch_total", 32'(launches), 32'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; tx_busy = 1'b0;

    //          rst   wr    data   busy  valid pdata  cnt  full  empty ovf   lerr
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 8'hA5, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h3C, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h3C, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 8'h3C, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h3C, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h3C, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h5A, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h5A, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h5A, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1};

    // Reset, single-byte latency, pacing on busy, and a launch timeout with a queued follower.
    for (int i = 0; i < 17; i++) begin
      rst = vecs[i].rst; wr_en = vecs[i].wr_en; wr_data = vecs[i].wr_data; tx_busy = vecs[i].busy;
      step();
      check($sformatf("v%0d_valid", i), 32'(tx_data_valid), 32'(vecs[i].valid));
      check($sformatf("v%0d_pdata", i), 32'(tx_p_data),     32'(vecs[i].p_data));
      check($sformatf("v%0d_count", i), 32'(count),         32'(vecs[i].count));
      check($sformatf("v%0d_full", i),  32'(full),          32'(vecs[i].full));
      check($sformatf("v%0d_empty", i), 32'(empty),         32'(vecs[i].empty));
      check($sformatf("v%0d_ovf", i),   32'(overflow),      32'(vecs[i].ovf));
      check($sformatf("v%0d_lerr", i),  32'(launch_err),    32'(vecs[i].lerr));
    end

    // Reset while in WAIT_DONE with five bytes still queued.
    wr_en = 1'b0; tx_busy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h61 + i);
      step();
    end
    wr_en = 1'b0; tx_busy = 1'b0;
    step();
    check("mid_launch_valid", 32'(tx_data_valid), 32'd1);
    check("mid_launch_data",  32'(tx_p_data),     32'h61);
    tx_busy = 1'b1;
    step();
    check("mid_count5", 32'(count), 32'd5);
    rst = 1'b1;
    step();
    check("rst_count", 32'(count),         32'd0);
    check("rst_empty", 32'(empty),         32'd1);
    check("rst_full",  32'(full),          32'd0);
    check("rst_lerr",  32'(launch_err),    32'd0);
    check("rst_ovf",   32'(overflow),      32'd0);
    check("rst_valid", 32'(tx_data_valid), 32'd0);
    check("rst_pdata", 32'(tx_p_data),     32'd0);
    wr_en = 1'b1; wr_data = 8'hFF; tx_busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_hold_valid", 32'(tx_data_valid), 32'd0);
      check("rst_hold_count", 32'(count),         32'd0);
    end
    rst = 1'b0; wr_en = 1'b0;

    // Single byte with a 10-cycle frame, then a three-byte burst with 11-cycle frames.
    wr_q  = '{8'hA5};
    exp_q = '{8'hA5};
    run_model(10, 100);
    expect_quiet(4);
    check("single_count", 32'(count), 32'd0);

    wr_q  = '{8'h11, 8'h22, 8'h33};
    exp_q = '{8'h11, 8'h22, 8'h33};
    run_model(11, 200);
    expect_quiet(4);
    check("burst_count", 32'(count), 32'd0);

    // Fill past capacity from non-zero pointers, then drain across the wrap.
    tx_busy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h80 + i);
      step();
      check($sformatf("fill%0d_count", i), 32'(count),    32'((i < 8) ? i + 1 : 8));
      check($sformatf("fill%0d_full", i),  32'(full),     32'((i >= 7) ? 1 : 0));
      check($sformatf("fill%0d_ovf", i),   32'(overflow), 32'((i == 8) ? 1 : 0));
    end
    wr_en = 1'b0;
    exp_q = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87};
    run_model(3, 300);
    check("drain_count", 32'(count), 32'd0);
    check("drain_ovf",   32'(overflow), 32'd1);

    // Write while full in the same cycle as a pop: the write is dropped.
    rst = 1'b1;
    step();
    rst = 1'b0; tx_busy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h40 + i);
      step();
    end
    check("coll_pre_full",  32'(full),  32'd1);
    check("coll_pre_count", 32'(count), 32'd8);
    wr_en = 1'b1; wr_data = 8'hEE; tx_busy = 1'b0;
    step();
    check("coll_valid", 32'(tx_data_valid), 32'd1);
    check("coll_pdata", 32'(tx_p_data),     32'h40);
    check("coll_count", 32'(count),         32'd7);
    check("coll_ovf",   32'(overflow),      32'd1);
    check("coll_full",  32'(full),          32'd0);
    wr_en = 1'b0; tx_busy = 1'b1;
    step();
    step();
    exp_q = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47};
    run_model(3, 300);
    expect_quiet(4);
    check("coll_end_count", 32'(count),      32'd0);
    check("coll_end_lerr",  32'(launch_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
